// File: rtl/hist_equalize_lut.sv
// Histogram-equalization LUT: builds a CDF-based remap table from a 256-bin
// histogram into a shadow bank, swaps it in at a frame boundary, and remaps pixels.
module hist_equalize_lut #(
  parameter int          BINS       = 256,
  parameter int          BIN_W      = 16,
  parameter int          CDF_W      = 24,
  parameter logic [11:0] NORM_MULT  = 12'd2804,
  parameter int          NORM_SHIFT = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hist_valid,
  output logic [7:0]       hist_addr_rd,
  input  logic [BIN_W-1:0] hist_data_rd,
  input  logic [7:0]       in_pixel,
  input  logic             in_valid,
  input  logic             end_of_frame,
  output logic [7:0]       out_pixel,
  output logic             out_valid,
  output logic             out_end_of_frame,
  output logic             busy,
  output logic             lut_swapped,
  output logic             hist_dropped
);

  localparam int PROD_W = CDF_W + 12;

  typedef enum logic [1:0] {IDLE, READ, FLUSH, READY} state_t;

  state_t            state, state_next;
  logic              start, swap;
  logic [1:0]        flush_cnt;
  logic              v1, v2, v3;
  logic [7:0]        idx1, idx2, idx3;
  logic [CDF_W-1:0]  cdf_acc;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] shifted;
  logic [7:0]        lut_val;
  logic              bank, lut_loaded;
  logic [7:0]        lut_mem [0:2*BINS-1];
  logic [7:0]        pix_d;
  logic              valid_d, eof_d, bank_d, loaded_d;

  assign busy = (state == READ) || (state == FLUSH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    swap       = 1'b0;
    case (state)
      IDLE:  if (hist_valid) begin
               state_next = READ;
               start      = 1'b1;
             end
      READ:  if (hist_addr_rd == 8'd255) state_next = FLUSH;
      FLUSH: if (flush_cnt == 2'd2) state_next = READY;
      READY: if (end_of_frame) begin
               state_next = IDLE;
               swap       = 1'b1;
             end
      default: state_next = IDLE;
    endcase
  end

  // Build pipeline: accumulate, scale, then clamp-and-write with the bin index
  // carried alongside so each result lands on the entry it was read from.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_addr_rd <= '0;
      flush_cnt    <= '0;
      v1           <= 1'b0;
      v2           <= 1'b0;
      v3           <= 1'b0;
      idx1         <= '0;
      idx2         <= '0;
      idx3         <= '0;
      cdf_acc      <= '0;
      prod         <= '0;
      bank         <= 1'b0;
      lut_loaded   <= 1'b0;
      lut_swapped  <= 1'b0;
      hist_dropped <= 1'b0;
    end else begin
      lut_swapped  <= swap;
      hist_dropped <= hist_valid && (state != IDLE);
      if (start)
        hist_addr_rd <= '0;
      else if (state == READ && hist_addr_rd != 8'd255)
        hist_addr_rd <= hist_addr_rd + 8'd1;
      flush_cnt <= (state == FLUSH) ? flush_cnt + 2'd1 : 2'd0;
      v1   <= (state == READ);
      idx1 <= hist_addr_rd;
      v2   <= v1;
      idx2 <= idx1;
      v3   <= v2;
      idx3 <= idx2;
      if (start)   cdf_acc <= '0;
      else if (v1) cdf_acc <= cdf_acc + CDF_W'(hist_data_rd);
      prod <= PROD_W'(cdf_acc) * PROD_W'(NORM_MULT);
      if (swap) begin
        bank       <= ~bank;
        lut_loaded <= 1'b1;
      end
    end
  end

  always_comb begin
    shifted = prod >> NORM_SHIFT;
    lut_val = (|shifted[PROD_W-1:8]) ? 8'hFF : shifted[7:0];
  end

  always_ff @(posedge clk) begin
    if (v3) lut_mem[{~bank, idx3}] <= lut_val;
  end

  // Bank select and loaded flag ride with each pixel so a swap never tears
  // a pixel that is already in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_d            <= '0;
      valid_d          <= 1'b0;
      eof_d            <= 1'b0;
      bank_d           <= 1'b0;
      loaded_d         <= 1'b0;
      out_pixel        <= '0;
      out_valid        <= 1'b0;
      out_end_of_frame <= 1'b0;
    end else begin
      pix_d            <= in_pixel;
      valid_d          <= in_valid;
      eof_d            <= end_of_frame;
      bank_d           <= bank;
      loaded_d         <= lut_loaded;
      out_pixel        <= loaded_d ? lut_mem[{bank_d, pix_d}] : pix_d;
      out_valid        <= valid_d;
      out_end_of_frame <= eof_d;
    end
  end

endmodule

// File: tb/tb_hist_equalize_lut.sv
// Self-checking bench for hist_equalize_lut: a cycle-level expectation model
// built from the documented latencies and a plain-arithmetic CDF golden map.
module tb_hist_equalize_lut;

  localparam longint unsigned NORM_MULT  = 2804;
  localparam int              NORM_SHIFT = 20;

  logic        clk;
  logic        rst;
  logic        hist_valid;
  logic [7:0]  hist_addr_rd;
  logic [15:0] hist_data_rd;
  logic [7:0]  in_pixel;
  logic        in_valid;
  logic        end_of_frame;
  logic [7:0]  out_pixel;
  logic        out_valid;
  logic        out_end_of_frame;
  logic        busy;
  logic        lut_swapped;
  logic        hist_dropped;

  hist_equalize_lut dut (
    .clk              (clk),
    .rst              (rst),
    .hist_valid       (hist_valid),
    .hist_addr_rd     (hist_addr_rd),
    .hist_data_rd     (hist_data_rd),
    .in_pixel         (in_pixel),
    .in_valid         (in_valid),
    .end_of_frame     (end_of_frame),
    .out_pixel        (out_pixel),
    .out_valid        (out_valid),
    .out_end_of_frame (out_end_of_frame),
    .busy             (busy),
    .lut_swapped      (lut_swapped),
    .hist_dropped     (hist_dropped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Histogram RAM with a one-cycle registered read port
  logic [15:0] hist_mem [256];
  always @(posedge clk) hist_data_rd <= hist_mem[hist_addr_rd];

  typedef struct {
    logic [7:0] pix;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    bit         valid;
    bit         eof;
    logic [7:0] pix;
  } exp_t;

  int         vectors;
  int         miscompares;
  int         cyc;
  int         build_start;
  bit         loaded;
  logic [7:0] active_map [256];
  logic [7:0] shadow_map [256];
  exp_t       pipe0, pipe1;
  vec_t       tbl [16];
  int         tbl_n;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  // Golden equalization map straight from the cumulative histogram
  function automatic void buildMap();
    longint unsigned cum;
    longint unsigned v;
    cum = 0;
    for (int p = 0; p < 256; p++) begin
      cum += longint'(hist_mem[p]);
      v = (cum * NORM_MULT) >> NORM_SHIFT;
      shadow_map[p] = (v > 255) ? 8'd255 : v[7:0];
    end
  endfunction

  // One clock: predict what the edge does to the model, clock, then compare
  task automatic step();
    exp_t e;
    bit   swap_now, drop_now, ready, idle;
    int   k;
    swap_now = 0;
    drop_now = 0;
    e.valid  = rst ? in_valid : 1'b0;
    e.eof    = rst ? end_of_frame : 1'b0;
    e.pix    = loaded ? active_map[in_pixel] : in_pixel;
    if (rst) begin
      ready = (build_start >= 0) && (cyc - build_start >= 260);
      idle  = (build_start < 0);
      if (hist_valid) begin
        if (idle) begin
          buildMap();
          build_start = cyc;
        end else begin
          drop_now = 1;
        end
      end
      if (end_of_frame && ready) begin
        for (int p = 0; p < 256; p++) active_map[p] = shadow_map[p];
        loaded      = 1;
        build_start = -1;
        swap_now    = 1;
      end
    end
    pipe1 = pipe0;
    pipe0 = e;
    @(posedge clk);
    #1;
    cyc++;
    k = cyc - build_start;
    checkOutput("busy", int'(busy), int'(build_start >= 0 && k >= 1 && k <= 259));
    if (build_start >= 0 && k >= 1 && k <= 256)
      checkOutput("hist_addr_rd", int'(hist_addr_rd), k - 1);
    checkOutput("lut_swapped", int'(lut_swapped), int'(swap_now));
    checkOutput("hist_dropped", int'(hist_dropped), int'(drop_now));
    checkOutput("out_valid", int'(out_valid), int'(pipe1.valid));
    checkOutput("out_end_of_frame", int'(out_end_of_frame), int'(pipe1.eof));
    if (pipe1.valid)
      checkOutput("out_pixel", int'(out_pixel), int'(pipe1.pix));
  endtask

  task automatic applyStimulus(input int n, input int eof_pct, input int hv_pct);
    for (int i = 0; i < n; i++) begin
      in_pixel     = 8'($urandom);
      in_valid     = ($urandom_range(0, 3) != 0);
      end_of_frame = ($urandom_range(0, 99) < eof_pct);
      hist_valid   = ($urandom_range(0, 99) < hv_pct);
      step();
    end
    end_of_frame = 1'b0;
    hist_valid   = 1'b0;
  endtask

  task automatic runTo(input int target);
    if (target > cyc) applyStimulus(target - cyc, 0, 0);
  endtask

  task automatic applyReset();
    rst = 1'b0;
    #1;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out_pixel", int'(out_pixel), 0);
    checkOutput("reset_lut_swapped", int'(lut_swapped), 0);
    checkOutput("reset_hist_addr_rd", int'(hist_addr_rd), 0);
    build_start  = -1;
    loaded       = 0;
    pipe0.valid  = 0;
    pipe0.eof    = 0;
    pipe1.valid  = 0;
    pipe1.eof    = 0;
    hist_valid   = 1'b0;
    in_valid     = 1'b0;
    end_of_frame = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic startBuild();
    hist_valid = 1'b1;
    step();
    hist_valid = 1'b0;
  endtask

  task automatic buildAndSwap();
    int a;
    a = cyc;
    startBuild();
    runTo(a + 260);
    end_of_frame = 1'b1;
    in_valid     = 1'b1;
    step();
    end_of_frame = 1'b0;
  endtask

  task automatic sweepPixels();
    for (int p = 0; p < 256; p++) begin
      in_pixel     = 8'(p);
      in_valid     = 1'b1;
      end_of_frame = 1'b0;
      step();
    end
  endtask

  task automatic runTable();
    for (int i = 0; i < tbl_n; i++) begin
      in_pixel = tbl[i].pix;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      checkOutput("table_pixel", int'(out_pixel), int'(tbl[i].exp));
    end
  endtask

  initial begin
    int a;
    vectors      = 0;
    miscompares  = 0;
    cyc          = 0;
    build_start  = -1;
    loaded       = 0;
    rst          = 1'b1;
    hist_valid   = 1'b0;
    in_pixel     = '0;
    in_valid     = 1'b0;
    end_of_frame = 1'b0;
    pipe0        = '{valid: 0, eof: 0, pix: 8'd0};
    pipe1        = '{valid: 0, eof: 0, pix: 8'd0};
    for (int p = 0; p < 256; p++) hist_mem[p] = 16'd0;
    #3;
    applyReset();

    $display("[TB] bypass stream before any histogram");
    sweepPixels();

    $display("[TB] two-spike histogram");
    for (int p = 0; p < 256; p++) hist_mem[p] = 16'd0;
    hist_mem[128] = 16'd65535;
    hist_mem[200] = 16'd65535;
    buildAndSwap();
    tbl_n = 6;
    tbl[0] = '{pix: 8'd0,   exp: 8'd0};
    tbl[1] = '{pix: 8'd127, exp: 8'd0};
    tbl[2] = '{pix: 8'd128, exp: 8'd175};
    tbl[3] = '{pix: 8'd199, exp: 8'd175};
    tbl[4] = '{pix: 8'd200, exp: 8'd255};
    tbl[5] = '{pix: 8'd255, exp: 8'd255};
    runTable();

    $display("[TB] uniform histogram");
    for (int p = 0; p < 256; p++) hist_mem[p] = 16'd1200;
    buildAndSwap();
    tbl_n = 10;
    tbl[0] = '{pix: 8'd0,   exp: 8'd3};
    tbl[1] = '{pix: 8'd1,   exp: 8'd6};
    tbl[2] = '{pix: 8'd2,   exp: 8'd9};
    tbl[3] = '{pix: 8'd10,  exp: 8'd35};
    tbl[4] = '{pix: 8'd50,  exp: 8'd163};
    tbl[5] = '{pix: 8'd77,  exp: 8'd250};
    tbl[6] = '{pix: 8'd78,  exp: 8'd253};
    tbl[7] = '{pix: 8'd79,  exp: 8'd255};
    tbl[8] = '{pix: 8'd127, exp: 8'd255};
    tbl[9] = '{pix: 8'd255, exp: 8'd255};
    runTable();
    sweepPixels();

    $display("[TB] hist_valid during a build is dropped");
    for (int p = 0; p < 256; p++) hist_mem[p] = 16'($urandom_range(0, 3000));
    a = cyc;
    startBuild();
    runTo(a + 100);
    hist_valid = 1'b1;
    step();
    hist_valid = 1'b0;
    runTo(a + 270);
    end_of_frame = 1'b1;
    step();
    end_of_frame = 1'b0;
    sweepPixels();

    $display("[TB] end_of_frame during READ, then in READY");
    for (int p = 0; p < 256; p++) hist_mem[p] = 16'($urandom_range(0, 2400));
    a = cyc;
    startBuild();
    runTo(a + 150);
    end_of_frame = 1'b1;
    in_valid     = 1'b1;
    step();
    end_of_frame = 1'b0;
    runTo(a + 300);
    end_of_frame = 1'b1;
    in_valid     = 1'b1;
    in_pixel     = 8'($urandom);
    step();
    end_of_frame = 1'b0;
    in_pixel     = 8'($urandom);
    step();
    step();
    sweepPixels();

    $display("[TB] reset in the middle of a build");
    for (int p = 0; p < 256; p++) hist_mem[p] = 16'($urandom_range(0, 1500));
    a = cyc;
    startBuild();
    runTo(a + 120);
    applyReset();
    sweepPixels();
    for (int p = 0; p < 256; p++) hist_mem[p] = 16'd1200;
    buildAndSwap();
    sweepPixels();

    $display("[TB] randomized traffic");
    for (int r = 0; r < 5; r++) begin
      if (build_start < 0) begin
        for (int p = 0; p < 256; p++)
          hist_mem[p] = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2000));
        startBuild();
      end
      applyStimulus(450, 2, 1);
    end
    sweepPixels();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
